// File: rtl/race_controller.sv
// Race sequencer: button-driven state machine, pre-race countdown, centisecond
// race timer, winner latch and leader tracking for two physics engines.
module race_controller #(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          COUNT_FROM = 3,
  parameter logic [13:0] TIME_MAX   = 14'd9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic [1:0]  p1_flag,
  input  logic [1:0]  p2_flag,
  input  logic        p1_finish,
  input  logic        p2_finish,
  output logic [2:0]  state,
  output logic [2:0]  countdown,
  output logic [13:0] race_time,
  output logic [1:0]  winner,
  output logic [1:0]  leader
);

  localparam int CS_DIV = CLK_FREQ / 100;
  localparam int SEC_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int CS_W   = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_FREQ - 1);
  localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(CS_DIV - 1);
  localparam logic [2:0]       CD_INIT  = 3'(COUNT_FROM);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTING   = 3'd1,
    S_COUNTDOWN = 3'd3,
    S_RACING    = 3'd4,
    S_PAUSE     = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t           r_state;
  logic             r_start_q, r_pause_q;
  logic [SEC_W-1:0] r_sec_cnt;
  logic [CS_W-1:0]  r_cs_cnt;
  logic [2:0]       r_countdown;
  logic [13:0]      r_race_time;
  logic [1:0]       r_winner, r_leader;

  logic w_start_e, w_pause_e;

  assign w_start_e = start_btn & ~r_start_q;
  assign w_pause_e = pause_btn & ~r_pause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_start_q   <= 1'b0;
      r_pause_q   <= 1'b0;
      r_sec_cnt   <= '0;
      r_cs_cnt    <= '0;
      r_countdown <= '0;
      r_race_time <= '0;
      r_winner    <= '0;
      r_leader    <= '0;
    end else begin
      r_start_q <= start_btn;
      r_pause_q <= pause_btn;
      case (r_state)
        S_IDLE: begin
          r_sec_cnt   <= '0;
          r_cs_cnt    <= '0;
          r_countdown <= '0;
          r_race_time <= '0;
          r_winner    <= '0;
          r_leader    <= '0;
          if (w_start_e) r_state <= S_SETTING;
        end
        S_SETTING: begin
          if (w_start_e) begin
            r_state     <= S_COUNTDOWN;
            r_countdown <= CD_INIT;
            r_sec_cnt   <= '0;
          end else if (w_pause_e) begin
            r_state <= S_IDLE;
          end
        end
        S_COUNTDOWN: begin
          if (r_sec_cnt == SEC_LAST) begin
            r_sec_cnt <= '0;
            if (r_countdown == 3'd1) begin
              r_state     <= S_RACING;
              r_countdown <= '0;
            end else begin
              r_countdown <= r_countdown - 3'd1;
            end
          end else begin
            r_sec_cnt <= r_sec_cnt + 1'b1;
          end
        end
        S_RACING: begin
          // Timer keeps running on the cycle that leaves RACING; PAUSE then freezes it.
          if (r_cs_cnt == CS_LAST) begin
            r_cs_cnt <= '0;
            if (r_race_time < TIME_MAX) r_race_time <= r_race_time + 14'd1;
          end else begin
            r_cs_cnt <= r_cs_cnt + 1'b1;
          end
          if (p1_flag > p2_flag)      r_leader <= 2'd1;
          else if (p2_flag > p1_flag) r_leader <= 2'd2;
          else                        r_leader <= 2'd0;
          if (p1_finish | p2_finish) begin
            r_state  <= S_FINISH;
            r_winner <= {p2_finish, p1_finish};
          end else if (w_pause_e) begin
            r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (w_start_e)      r_state <= S_IDLE;
          else if (w_pause_e) r_state <= S_RACING;
        end
        S_FINISH: begin
          if (w_start_e) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state     = r_state;
  assign countdown = r_countdown;
  assign race_time = r_race_time;
  assign winner    = r_winner;
  assign leader    = r_leader;

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares them.
module tb_race_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn, pause_btn;
  logic [1:0]  p1_flag, p2_flag;
  logic        p1_finish, p2_finish;
  logic [2:0]  state, countdown;
  logic [13:0] race_time;
  logic [1:0]  winner, leader;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string nm;
    int    st, cd, rt, wn, ld;   // -1 = don't care
  } exp_t;

  exp_t exp_q[$];

  race_controller #(
    .CLK_FREQ  (1000),
    .COUNT_FROM(3),
    .TIME_MAX  (14'd60)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .pause_btn (pause_btn),
    .p1_flag   (p1_flag),
    .p2_flag   (p2_flag),
    .p1_finish (p1_finish),
    .p2_finish (p2_finish),
    .state     (state),
    .countdown (countdown),
    .race_time (race_time),
    .winner    (winner),
    .leader    (leader)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int st, input int cd,
                            input int rt, input int wn, input int ld);
    exp_t e;
    e.nm = nm; e.st = st; e.cd = cd; e.rt = rt; e.wn = wn; e.ld = ld;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    if (req >= 0) begin
      checks++;
      if (act != req) begin
        errors++;
        $display("FAIL %s.%s: got %0d required %0d", nm, fld, act, req);
      end
    end
  endtask

  // Monitor: outputs are stable between the post-edge stimulus point and negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.nm, "state",     int'(state),     e.st);
      cmp(e.nm, "countdown", int'(countdown), e.cd);
      cmp(e.nm, "race_time", int'(race_time), e.rt);
      cmp(e.nm, "winner",    int'(winner),    e.wn);
      cmp(e.nm, "leader",    int'(leader),    e.ld);
    end
  end

  task automatic start_edge();
    start_btn = 1'b1; tick(1);
    start_btn = 1'b0; tick(1);
  endtask

  // From IDLE to the first RACING cycle.
  task automatic go_race(input string nm);
    start_btn = 1'b1; tick(1);
    start_btn = 1'b0; tick(1);
    start_btn = 1'b1; tick(1);
    start_btn = 1'b0; tick(3000);
    expect_out(nm, 4, 0, 0, 0, -1);
  endtask

  initial begin
    rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0;
    p1_flag = 2'd0; p2_flag = 2'd0; p1_finish = 1'b0; p2_finish = 1'b0;
    tick(3);
    expect_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0; tick(1);

    // Countdown sequence
    start_btn = 1'b1; tick(1);
    expect_out("to_setting", 1, 0, 0, 0, 0);
    start_btn = 1'b0; tick(1);
    start_btn = 1'b1; tick(1);
    expect_out("cd_start", 3, 3, 0, 0, 0);
    start_btn = 1'b0; tick(999);
    expect_out("cd_3_last", 3, 3, 0, 0, 0);
    tick(1);
    expect_out("cd_2", 3, 2, 0, 0, 0);
    tick(1000);
    expect_out("cd_1", 3, 1, 0, 0, 0);
    tick(999);
    expect_out("cd_1_last", 3, 1, 0, 0, 0);
    tick(1);
    expect_out("racing", 4, 0, 0, 0, 0);

    // Timer, pause/resume, leader
    p1_flag = 2'd2; p2_flag = 2'd1;
    tick(500);
    expect_out("rt_50", 4, 0, 50, 0, 1);
    pause_btn = 1'b1; tick(1);
    expect_out("paused", 5, 0, 50, 0, 1);
    pause_btn = 1'b0; p1_finish = 1'b1;
    tick(300);
    expect_out("pause_hold", 5, 0, 50, 0, 1);
    p1_finish = 1'b0;
    pause_btn = 1'b1; tick(1);
    expect_out("resumed", 4, 0, 50, 0, 1);
    pause_btn = 1'b0; tick(10);
    expect_out("rt_51", 4, 0, 51, 0, 1);
    p2_flag = 2'd3; tick(1);
    expect_out("leader_2", 4, 0, 51, 0, 2);
    p1_flag = 2'd3; tick(1);
    expect_out("leader_lvl", 4, 0, 51, 0, 0);

    // Finish by car 2
    p2_finish = 1'b1; tick(1);
    expect_out("fin_p2", 6, 0, 51, 2, 0);
    p2_finish = 1'b0; pause_btn = 1'b1; tick(20);
    expect_out("fin_hold", 6, 0, 51, 2, 0);
    pause_btn = 1'b0;
    start_edge(); tick(1);
    expect_out("fin_abort", 0, 0, 0, 0, 0);

    // Tie
    go_race("race2");
    p1_finish = 1'b1; p2_finish = 1'b1; tick(1);
    expect_out("fin_tie", 6, 0, 0, 3, -1);
    p1_finish = 1'b0; p2_finish = 1'b0;
    start_edge(); tick(1);
    expect_out("tie_idle", 0, 0, 0, 0, 0);

    // Held start level is one event; pause in SETTING cancels
    start_btn = 1'b1; tick(50);
    expect_out("held_start", 1, 0, 0, 0, 0);
    start_btn = 1'b0; tick(1);
    pause_btn = 1'b1; tick(1);
    expect_out("set_cancel", 0, 0, 0, 0, 0);
    pause_btn = 1'b0; tick(1);

    // Saturation, pause then abort
    go_race("race3");
    tick(700);
    expect_out("rt_sat", 4, 0, 60, 0, -1);
    pause_btn = 1'b1; tick(1);
    expect_out("sat_pause", 5, 0, 60, 0, -1);
    pause_btn = 1'b0; tick(1);
    start_btn = 1'b1; tick(1);
    expect_out("pause_abort", 0, -1, -1, -1, -1);
    start_btn = 1'b0; tick(1);
    expect_out("abort_idle", 0, 0, 0, 0, 0);

    // start wins over pause in SETTING; buttons ignored in COUNTDOWN; reset mid-countdown
    start_edge();
    start_btn = 1'b1; pause_btn = 1'b1; tick(1);
    expect_out("both_btn", 3, 3, 0, 0, 0);
    start_btn = 1'b0; pause_btn = 1'b0; tick(500);
    pause_btn = 1'b1; tick(1);
    expect_out("cd_ignore", 3, 3, 0, 0, 0);
    pause_btn = 1'b0; tick(499);
    expect_out("cd_2b", 3, 2, 0, 0, 0);
    rst = 1'b1; tick(1);
    expect_out("rst_mid", 0, 0, 0, 0, 0);
    rst = 1'b0; tick(2);
    expect_out("post_rst", 0, 0, 0, 0, 0);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
